// File: rtl/fft_8p_stream.sv
// Streaming 8-point radix-2 DIT FFT/IFFT: three registered butterfly stages with per-stage ready.
// Optional clamping arithmetic and sticky sat_flag port enabled by defining FFT_SAT_EN.

module fft_8p_bfly #(
  parameter int WIDTH    = 32,
  parameter int Q_LENGTH = 16,
  parameter int SCALE    = 0
) (
  input  logic signed [WIDTH-1:0] ar,
  input  logic signed [WIDTH-1:0] ai,
  input  logic signed [WIDTH-1:0] br,
  input  logic signed [WIDTH-1:0] bi,
  input  logic signed [WIDTH-1:0] wr,
  input  logic signed [WIDTH-1:0] wi,
  output logic signed [WIDTH-1:0] xr,
  output logic signed [WIDTH-1:0] xi,
  output logic signed [WIDTH-1:0] yr,
  output logic signed [WIDTH-1:0] yi
`ifdef FFT_SAT_EN
  , output logic                  sat
`endif
);
  localparam int PW = 2*WIDTH + 1;
  localparam int W1 = WIDTH + 1;
  localparam int SH = (SCALE != 0) ? 1 : 0;

  logic signed [2*WIDTH-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [WIDTH-1:0]   p_r, p_i;

  assign m_rr = (2*WIDTH)'(br) * (2*WIDTH)'(wr);
  assign m_ii = (2*WIDTH)'(bi) * (2*WIDTH)'(wi);
  assign m_ri = (2*WIDTH)'(br) * (2*WIDTH)'(wi);
  assign m_ir = (2*WIDTH)'(bi) * (2*WIDTH)'(wr);

`ifdef FFT_SAT_EN
  // A value fits WIDTH bits when everything above the WIDTH-1 sign bit repeats it.
  function automatic logic ovf(input logic signed [PW-1:0] v);
    return !((&v[PW-1:WIDTH-1]) || !(|v[PW-1:WIDTH-1]));
  endfunction

  function automatic logic [WIDTH-1:0] fit(input logic signed [PW-1:0] v);
    return ovf(v) ? {v[PW-1], {(WIDTH-1){~v[PW-1]}}} : v[WIDTH-1:0];
  endfunction

  logic signed [PW-1:0] pr_w, pi_w;
  logic signed [W1-1:0] sx_r, sx_i, sy_r, sy_i;

  assign pr_w = (PW'(m_rr) - PW'(m_ii)) >>> Q_LENGTH;
  assign pi_w = (PW'(m_ri) + PW'(m_ir)) >>> Q_LENGTH;
  assign p_r  = fit(pr_w);
  assign p_i  = fit(pi_w);

  assign sx_r = (W1'(ar) + W1'(p_r)) >>> SH;
  assign sx_i = (W1'(ai) + W1'(p_i)) >>> SH;
  assign sy_r = (W1'(ar) - W1'(p_r)) >>> SH;
  assign sy_i = (W1'(ai) - W1'(p_i)) >>> SH;

  assign xr  = fit(PW'(sx_r));
  assign xi  = fit(PW'(sx_i));
  assign yr  = fit(PW'(sy_r));
  assign yi  = fit(PW'(sy_i));
  assign sat = ovf(pr_w) | ovf(pi_w) | ovf(PW'(sx_r)) | ovf(PW'(sx_i))
             | ovf(PW'(sy_r)) | ovf(PW'(sy_i));
`else
  assign p_r = WIDTH'((PW'(m_rr) - PW'(m_ii)) >>> Q_LENGTH);
  assign p_i = WIDTH'((PW'(m_ri) + PW'(m_ir)) >>> Q_LENGTH);
  assign xr  = WIDTH'((W1'(ar) + W1'(p_r)) >>> SH);
  assign xi  = WIDTH'((W1'(ai) + W1'(p_i)) >>> SH);
  assign yr  = WIDTH'((W1'(ar) - W1'(p_r)) >>> SH);
  assign yi  = WIDTH'((W1'(ai) - W1'(p_i)) >>> SH);
`endif
endmodule

module fft_8p_stream #(
  parameter int WIDTH    = 32,
  parameter int Q_LENGTH = 16,
  parameter int SCALE    = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*WIDTH-1:0] in_real,
  input  logic [8*WIDTH-1:0] in_img,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_inv,
  output logic [8*WIDTH-1:0] out_real,
  output logic [8*WIDTH-1:0] out_img
`ifdef FFT_SAT_EN
  , output logic             sat_flag
`endif
);
  localparam int STAGES = 3;
  localparam int CI     = int'(0.70710678 * (2.0 ** Q_LENGTH));
  localparam logic [WIDTH-1:0] T_ONE = WIDTH'(1) << Q_LENGTH;
  // Twiddles W0..W3, index 3 in the top slot.
  localparam logic [3:0][WIDTH-1:0] TW_R = {WIDTH'(-CI), WIDTH'(0), WIDTH'(CI), T_ONE};
  localparam logic [3:0][WIDTH-1:0] TW_I = {WIDTH'(-CI), -T_ONE, WIDTH'(-CI), WIDTH'(0)};

  logic [STAGES-1:0]                    vld_pipe, inv_pipe, rdy, v_src, inv_src;
  logic [STAGES-1:0][7:0][WIDTH-1:0]    st_r, st_i, src_r, src_i, bf_r, bf_i;

  function automatic int brev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  // A stage can load whenever it or anything downstream of it has room.
  assign rdy      = {~vld_pipe[2] | out_ready, ~&vld_pipe[2:1] | out_ready, ~&vld_pipe | out_ready};
  assign in_ready = rdy[0];
  assign v_src    = {vld_pipe[1:0], in_valid};
  assign inv_src  = {inv_pipe[1:0], in_inv};

  always_comb begin
    src_r = '0;
    src_i = '0;
    for (int n = 0; n < 8; n++) begin
      src_r[0][n] = in_real[brev(n)*WIDTH +: WIDTH];
      src_i[0][n] = in_img[brev(n)*WIDTH +: WIDTH];
    end
    for (int s = 1; s < STAGES; s++) begin
      src_r[s] = st_r[s-1];
      src_i[s] = st_i[s-1];
    end
  end

`ifdef FFT_SAT_EN
  logic [STAGES-1:0][3:0] bf_sat;
  logic [STAGES-1:0]      stage_sat;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    for (genvar j = 0; j < 4; j++) begin : g_bf
      localparam int SPAN = 1 << s;
      localparam int M    = j % SPAN;
      localparam int I0   = (j / SPAN) * 2 * SPAN + M;
      localparam int I1   = I0 + SPAN;
      localparam int K    = M * (4 >> s);
      logic [WIDTH-1:0] wi;
      assign wi = inv_src[s] ? -TW_I[K] : TW_I[K];
      fft_8p_bfly #(.WIDTH(WIDTH), .Q_LENGTH(Q_LENGTH), .SCALE(SCALE)) u_bf (
        .ar(src_r[s][I0]), .ai(src_i[s][I0]),
        .br(src_r[s][I1]), .bi(src_i[s][I1]),
        .wr(TW_R[K]),      .wi(wi),
        .xr(bf_r[s][I0]),  .xi(bf_i[s][I0]),
        .yr(bf_r[s][I1]),  .yi(bf_i[s][I1])
`ifdef FFT_SAT_EN
        , .sat(bf_sat[s][j])
`endif
      );
    end
`ifdef FFT_SAT_EN
    assign stage_sat[s] = |bf_sat[s];
`endif
  end

  // Loading stages take whatever is upstream, bubbles included; that is what collapses gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      inv_pipe <= '0;
      st_r     <= '0;
      st_i     <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (rdy[s]) begin
          vld_pipe[s] <= v_src[s];
          inv_pipe[s] <= inv_src[s];
          st_r[s]     <= bf_r[s];
          st_i[s]     <= bf_i[s];
        end
      end
    end
  end

`ifdef FFT_SAT_EN
  always_ff @(posedge clk) begin
    if (reset)                              sat_flag <= 1'b0;
    else if (|(rdy & v_src & stage_sat))    sat_flag <= 1'b1;
  end
`endif

  assign out_valid = vld_pipe[STAGES-1];
  assign out_inv   = inv_pipe[STAGES-1];
  assign out_real  = st_r[STAGES-1];
  assign out_img   = st_i[STAGES-1];
endmodule

// File: tb/tb_fft_8p_stream.sv
// Directed bench for fft_8p_stream: vector table, backpressure and mid-stream reset sequences.
module tb_fft_8p_stream;
  localparam logic [31:0] ONE = 32'h0001_0000, NEG = 32'hFFFF_0000;
  localparam logic [31:0] C   = 32'h0000_B505, NC  = 32'hFFFF_4AFB;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_inv, out_ready;
  logic         in_ready, out_valid, out_inv, s_in_ready, s_out_valid, s_out_inv;
  logic [255:0] in_real, in_img, out_real, out_img, s_out_real, s_out_img;
`ifdef FFT_SAT_EN
  logic         sat_flag, s_sat_flag;
`endif

  always #5 clk = ~clk;

  fft_8p_stream #(.WIDTH(32), .Q_LENGTH(16), .SCALE(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_real(in_real), .in_img(in_img), .out_valid(out_valid), .out_ready(out_ready),
    .out_inv(out_inv), .out_real(out_real), .out_img(out_img)
`ifdef FFT_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  fft_8p_stream #(.WIDTH(32), .Q_LENGTH(16), .SCALE(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_inv(in_inv),
    .in_real(in_real), .in_img(in_img), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_inv(s_out_inv), .out_real(s_out_real), .out_img(s_out_img)
`ifdef FFT_SAT_EN
    , .sat_flag(s_sat_flag)
`endif
  );

  typedef struct {
    logic         inv;
    logic [255:0] xr, xi, er, ei;
    logic [31:0]  es0;
  } vec_t;

  vec_t tv[7];
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] pk(input logic [31:0] v0, v1, v2, v3, v4, v5, v6, v7);
    return {v7, v6, v5, v4, v3, v2, v1, v0};
  endfunction

  function automatic logic [255:0] fin(input int i);
    return pk(32'((i + 1) << 16), 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [255:0] fout(input int i);
    return {8{32'((i + 1) << 16)}};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sat_x0;
    int          sent, got;
    logic        stall_prev;
    logic [255:0] hold_r;

`ifdef FFT_SAT_EN
    sat_x0 = 32'h7FFF_FFFF;
`else
    sat_x0 = 32'h0000_0000;
`endif
    tv[0] = '{1'b0, pk(ONE,0,0,0,0,0,0,0), '0, {8{ONE}}, '0, 32'h2000};
    tv[1] = '{1'b0, {8{ONE}}, '0, pk(32'h0008_0000,0,0,0,0,0,0,0), '0, ONE};
    tv[2] = '{1'b0, pk(0,ONE,0,0,0,0,0,0), '0,
              pk(ONE, C, 0, NC, NEG, NC, 0, C), pk(0, NC, NEG, NC, 0, C, ONE, C), 32'h2000};
    tv[3] = '{1'b1, pk(0,ONE,0,0,0,0,0,0), '0,
              pk(ONE, C, 0, NC, NEG, NC, 0, C), pk(0, C, ONE, C, 0, NC, NEG, NC), 32'h2000};
    tv[4] = '{1'b0, '0, pk(ONE,0,0,0,0,0,0,0), '0, {8{ONE}}, 32'h0};
    tv[5] = '{1'b0, pk(0,0,ONE,0,0,0,0,0), '0,
              pk(ONE, 0, NEG, 0, ONE, 0, NEG, 0), pk(0, NEG, 0, ONE, 0, NEG, 0, ONE), 32'h2000};
    tv[6] = '{1'b0, {8{32'h4000_0000}}, '0, pk(sat_x0,0,0,0,0,0,0,0), '0, 32'h4000_0000};

    reset = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b1;
    in_real = '0; in_img = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_inv", out_inv, 0);
    chk("reset_out_real", out_real, 0);
    chk("reset_out_img", out_img, 0);
    chk("reset_in_ready", in_ready, 1);
`ifdef FFT_SAT_EN
    chk("reset_sat_flag", sat_flag, 0);
`endif
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
`ifdef FFT_SAT_EN
      if (v == 6) chk("sat_flag_before", sat_flag, 0);
`endif
      @(posedge clk); #1;
      in_valid = 1'b1; in_inv = tv[v].inv; in_real = tv[v].xr; in_img = tv[v].xi;
      #1 chk($sformatf("v%0d_in_ready", v), in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_early_valid", v), out_valid, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", v), out_valid, 1);
      chk($sformatf("v%0d_out_inv", v), out_inv, tv[v].inv);
      chk($sformatf("v%0d_out_real", v), out_real, tv[v].er);
      chk($sformatf("v%0d_out_img", v), out_img, tv[v].ei);
      chk($sformatf("v%0d_scaled_x0", v), s_out_real[31:0], tv[v].es0);
    end
`ifdef FFT_SAT_EN
    chk("sat_flag_after", sat_flag, 1);
`endif

    // Backpressure: six frames back to back, downstream stalled for cycles 2..7.
    sent = 0; got = 0; stall_prev = 1'b0; hold_r = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 2 && c <= 7);
      in_valid  = (sent < 6);
      in_inv    = 1'b0;
      in_real   = fin(sent);
      in_img    = '0;
      #1;
      chk("bp_in_ready", in_ready, ((sent - got) < 3) || out_ready);
      if (stall_prev) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", out_real, hold_r);
      end
      if (out_valid && out_ready) begin
        chk("bp_order", out_real, fout(got));
        chk("bp_img", out_img, 0);
        got++;
      end
      if (in_valid && in_ready) sent++;
      stall_prev = out_valid && !out_ready;
      hold_r     = out_real;
    end
    in_valid = 1'b0;
    chk("bp_sent", sent, 6);
    chk("bp_received", got, 6);
    repeat (3) @(posedge clk);
    #1 chk("bp_drained", out_valid, 0);

    // Reset with three inverse frames in flight and the output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_inv = 1'b1; in_real = fin(i); in_img = '0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1);
    chk("rst_pre_in_ready", in_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inv", out_inv, 0);
    chk("rst_out_real", out_real, 0);
    chk("rst_out_img", out_img, 0);
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("rst_no_ghost", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
